regfile_read_arbiter: RTL and testbench

- Shares one 64-bit register-file read port (5-bit select into the 64-wide 32:1 read mux) among NUM_REQ requesters, e.g. decode, forwarding check and debug peek.
- Round-robin arbitration with a req/gnt handshake and a registered one-cycle response path back to the granted requester.
- Sits between the CPU requesters and the register file's read mux; drives the mux select and captures the mux output.

---
 rtl/regfile_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 36 +++
 rtl/regfile_read_arbiter.sv | 77 +++++++
 tb/tb_regfile_read_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared constants and types for the register-file read-port arbiter.
// Holds the XZR index and the default requester count.
package regfile_arb_pkg;

    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned DATA_W      = 64;
    localparam int unsigned DEF_NUM_REQ = 4;

    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t XZR_ADDR = 5'd31;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr wins.
// The search wraps modulo NUM_REQ and returns a one-hot grant plus a found flag.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       found
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    // One extra bit on sum so the wrap works for non-power-of-two NUM_REQ.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares one register-file read port among NUM_REQ requesters with round-robin
// grants and a registered one-cycle response; reads of XZR return zero.
module regfile_read_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ADDR_W  = regfile_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W  = regfile_arb_pkg::DATA_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [ADDR_W-1:0]              rd_sel,
    input  logic [DATA_W-1:0]              rd_data_in,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_W-1:0]              rsp_data
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0] pick_req;
    logic               found;

    // Gating the picker input keeps gnt low during stall and while reset is held.
    assign pick_req = req & {NUM_REQ{~stall & ~reset}};

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req  (pick_req),
        .ptr  (rr_ptr_q),
        .gnt  (gnt),
        .found(found)
    );

    // AND-OR select so unknown addresses on ungranted lanes never reach rd_sel.
    always_comb begin
        rd_sel   = '0;
        rr_ptr_d = rr_ptr_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            rd_sel = rd_sel | (req_addr[k] & {ADDR_W{gnt[k]}});
            if (gnt[k]) begin
                rr_ptr_d = (k == NUM_REQ - 1) ? '0 : PTR_W'(k + 1);
            end
        end
    end

    always_comb begin
        rsp_valid_d = gnt;
        rsp_data_d  = rsp_data_q;
        if (found) begin
            rsp_data_d = (rd_sel == ADDR_W'(XZR_ADDR)) ? '0 : rd_data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter: a reference round-robin model
// predicts grants, expected responses are queued and compared one cycle later.
module tb_regfile_read_arbiter;

    logic             clk;
    logic             reset;
    logic             stall;
    logic [3:0]       req;
    logic [3:0][4:0]  req_addr;
    logic [3:0]       gnt;
    logic [4:0]       rd_sel;
    logic [63:0]      rd_data_in;
    logic [3:0]       rsp_valid;
    logic [63:0]      rsp_data;

    logic [63:0]      regmem [32];

    typedef struct {
        logic [3:0]  valid;
        logic [63:0] data;
    } rsp_t;

    rsp_t        sb_q[$];
    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned m_ptr;
    logic [63:0] m_hold;

    regfile_read_arbiter #(
        .NUM_REQ(4),
        .ADDR_W (5),
        .DATA_W (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .rd_sel    (rd_sel),
        .rd_data_in(rd_data_in),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    assign rd_data_in = regmem[rd_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, required finish before 100000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Entered at posedge+1; drives one cycle and checks grant, then the response.
    task automatic cycle(input logic [3:0] r, input logic st);
        int          k;
        logic [3:0]  exp_g;
        logic [4:0]  exp_sel;
        logic [4:0]  a;
        rsp_t        e;
        rsp_t        got_e;
        req   = r;
        stall = st;
        #3;
        k       = -1;
        exp_g   = 4'b0000;
        exp_sel = 5'd0;
        if (!st) begin
            for (int i = 0; i < 4; i++) begin
                int j;
                j = (int'(m_ptr) + i) % 4;
                if (k < 0 && r[j]) k = j;
            end
        end
        if (k >= 0) begin
            exp_g[k] = 1'b1;
            a        = req_addr[k];
            exp_sel  = a;
            m_hold   = (a == 5'd31) ? 64'd0 : regmem[a];
            m_ptr    = (k + 1) % 4;
        end
        check("gnt", {60'd0, gnt}, {60'd0, exp_g});
        check("rd_sel", {59'd0, rd_sel}, {59'd0, exp_sel});
        e.valid = exp_g;
        e.data  = m_hold;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            got_e = sb_q.pop_front();
            check("rsp_valid", {60'd0, rsp_valid}, {60'd0, got_e.valid});
            check("rsp_data", rsp_data, got_e.data);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_ptr    = 0;
        m_hold   = '0;
        for (int i = 0; i < 32; i++) regmem[i] = 64'(i) * 64'h0101;
        regmem[7]  = 64'h7;
        regmem[31] = 64'hDEADBEEF_CAFEF00D;
        reset    = 1'b1;
        stall    = 1'b0;
        req      = 4'b0000;
        req_addr = {5'd12, 5'd9, 5'd5, 5'd3};

        repeat (2) @(posedge clk);
        #1;
        check("reset_gnt", {60'd0, gnt}, 64'd0);
        check("reset_rsp_valid", {60'd0, rsp_valid}, 64'd0);
        check("reset_rsp_data", rsp_data, 64'd0);
        reset = 1'b0;

        // Run a couple of grants, then hit reset mid-cycle with all requests up.
        cycle(4'b1111, 1'b0);
        cycle(4'b1111, 1'b0);
        req = 4'b1111;
        #3;
        reset = 1'b1;
        #1;
        check("midreset_gnt", {60'd0, gnt}, 64'd0);
        check("midreset_rd_sel", {59'd0, rd_sel}, 64'd0);
        check("midreset_rsp_valid", {60'd0, rsp_valid}, 64'd0);
        check("midreset_rsp_data", rsp_data, 64'd0);
        sb_q.delete();
        m_ptr  = 0;
        m_hold = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(4'b0000, 1'b0);

        // Round robin over eight cycles starting from requester 0.
        for (int n = 0; n < 8; n++) cycle(4'b1111, 1'b0);

        // Single read of X7 with an unknown address on an idle lane.
        req_addr[2] = 5'd7;
        req_addr[0] = 5'bxxxxx;
        cycle(4'b0100, 1'b0);
        req_addr[0] = 5'd3;

        // Pointer now at 3; requester 3 absent so wrap straight to 0 then 1.
        cycle(4'b0011, 1'b0);
        cycle(4'b0011, 1'b0);

        // XZR read returns zero even though the mux drives nonzero data.
        req_addr[1] = 5'd31;
        cycle(4'b0010, 1'b0);
        req_addr[1] = 5'd9;

        // Grant to 3, then stall three cycles; response still arrives.
        cycle(4'b1000, 1'b0);
        for (int n = 0; n < 3; n++) cycle(4'b1010, 1'b1);
        cycle(4'b1010, 1'b0);
        cycle(4'b0000, 1'b0);

        // Random traffic against the model.
        for (int n = 0; n < 40; n++) begin
            for (int q = 0; q < 4; q++) req_addr[q] = 5'($urandom_range(0, 31));
            cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
